fetch_prefetch_queue: RTL and testbench
=======================================

// Module: fetch_prefetch_queue
// PURPOSE
//  Instruction prefetch stage between unified memory and the instruction decoder of tinker_core.
//  Issues in-order 32-bit fetch requests over a valid/ready handshake and buffers returned words with their PC.
//  Presents {pc, instr} to decode; branch redirects from control flush the queue and discard stale responses.
// PARAMETERS
//  DEPTH     4         queue entries = max (occupancy + outstanding requests); power of 2, >=2
//  RESET_PC  64'h2000  fetch PC after reset
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   asynchronous, active-high reset
//  mem_req_valid  out  1   fetch request valid
//  mem_req_addr   out  64  fetch address, bits [1:0] always 0
//  mem_req_ready  in   1   memory accepts request this cycle
//  mem_rsp_valid  in   1   memory returns a word this cycle (in request order)
//  mem_rsp_data   in   32  returned instruction word
//  out_valid      out  1   head entry valid
//  out_pc         out  64  PC of head entry
//  out_instr      out  32  instruction of head entry
//  out_ready      in   1   decoder consumes head this cycle
//  redirect       in   1   branch taken: flush, refetch from redirect_pc
//  redirect_pc    in   64  new fetch PC; bits [1:0] forced to 0
//  err_unexp_rsp  out  1   sticky: mem_rsp_valid seen with zero outstanding
// BEHAVIOUR
//  Reset (async): state=RUN, fetch_pc=RESET_PC, occupancy=0, outstanding=0, err_unexp_rsp=0.
//   Outputs during reset: mem_req_valid=0, out_valid=0, out_pc=0, out_instr=0; mem_req_addr=RESET_PC.
//  States: RUN (normal), DRAIN (discarding stale responses).
//  Issue: mem_req_valid = (state==RUN) && !redirect && (occupancy+outstanding < DEPTH).
//   mem_req_addr = fetch_pc. Accept (valid&&ready): fetch_pc += 4 (mod 2^64 wrap), outstanding++.
//  Response in RUN, no redirect: push {pc_of_request, data}; space guaranteed by credit rule.
//   Request PC tracked by a response-PC register advanced +4 per accepted response.
//  Latency: response in cycle M -> out_valid high in cycle M+1. No combinational bypass.
//  Pop: out_valid && out_ready removes head. Push and pop same cycle: occupancy unchanged.
//  out_valid = occupancy!=0; out_pc/out_instr = 0 when empty.
//  Any response: outstanding-- (same-cycle accept and response net to zero change).
//  Redirect (either state): queue cleared, fetch_pc=redirect_pc & ~3, response-PC = same; any
//   response or pop in that cycle discarded/ignored. Next state: DRAIN if outstanding after this
//   cycle's response > 0, else RUN.
//  DRAIN: no requests issued; every response dropped; -> RUN when outstanding reaches 0
//   (first request issues the cycle after). Redirect in DRAIN updates fetch_pc, stays DRAIN.
//  mem_rsp_valid with outstanding==0: word dropped, counters unchanged, err_unexp_rsp<=1.
//  Counters sized $clog2(DEPTH)+1; never exceed DEPTH.
// STRUCTURE
//  tinker_pkg: RESET_PC default, INSTR_W=32, ADDR_W=64, fetch_entry_t {pc[63:0], instr[31:0]},
//   pfq_state_e {RUN, DRAIN}.
//  One sub-module: fetch_fifo (DEPTH-entry synchronous FIFO of fetch_entry_t, flush input,
//   count output); FSM, credit and PC logic stay in fetch_prefetch_queue.
// TESTING
//  1 Reset, ready=1, rsp 1 cycle after accept, out_ready=1 -> addrs 0x2000,0x2004,..; out_pc
//    follows in order, out_instr matches data, one instruction per cycle steady state.
//  2 out_ready=0, DEPTH=4 -> exactly 4 requests accepted, then mem_req_valid=0; occupancy 4;
//    one pop -> exactly one new request.
//  3 2 outstanding, redirect_pc=0x3003 -> out_valid=0 next cycle; 2 responses dropped in DRAIN;
//    next request addr 0x3000 only after second stale response; out_pc=0x3000 first.
//  4 Redirect with 0 outstanding -> RUN; request for redirect_pc next cycle; pop same cycle ignored.
//  5 Response with redirect same cycle, outstanding=1 -> dropped, state RUN, no DRAIN.
//  6 fetch_pc=64'hFFFF_FFFF_FFFF_FFFC accepted -> next addr 0; unsolicited rsp -> err_unexp_rsp=1
//    until reset; reset asserted mid-DRAIN -> all outputs reset values immediately.

Source files
------------

// File: rtl/tinker_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tinker_pkg
// Description : Shared types and widths for the tinker_core fetch path.
// Revision    : 1.0 - initial release
// ============================================================================
package tinker_pkg;

    localparam int              INSTR_W          = 32;
    localparam int              ADDR_W           = 64;
    localparam logic [63:0]     DEFAULT_RESET_PC = 64'h2000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } pfq_state_e;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : DEPTH-entry synchronous FIFO of fetch entries with flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import tinker_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int               PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0]   C_DEPTH = (PTR_W+1)'(DEPTH);

    fetch_entry_t     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push    = push && (r_count != C_DEPTH);
    assign w_pop     = pop && (r_count != '0);
    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
        end
    end

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_push && !flush) r_mem[r_wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : In-order instruction prefetch with credit-limited issue and
//               redirect flush / stale-response drain.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue
    import tinker_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic               mem_req_valid,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_req_ready,
    input  logic               mem_rsp_valid,
    input  logic [INSTR_W-1:0] mem_rsp_data,
    output logic               out_valid,
    output logic [ADDR_W-1:0]  out_pc,
    output logic [INSTR_W-1:0] out_instr,
    input  logic               out_ready,
    input  logic               redirect,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               err_unexp_rsp
);

    localparam int                CNT_W     = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0]    C_DEPTH   = (CNT_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] C_PC_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

    pfq_state_e        r_state;
    pfq_state_e        w_state_next;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [ADDR_W-1:0] w_redirect_pc;
    logic [CNT_W-1:0]  r_outstanding;
    logic [CNT_W-1:0]  w_outstanding_next;
    logic [CNT_W-1:0]  w_fifo_count;
    logic [CNT_W:0]    w_credit_used;
    logic              r_err_unexp;
    logic              w_accept;
    logic              w_rsp_ok;
    logic              w_push;
    logic              w_pop;
    fetch_entry_t      w_push_entry;
    fetch_entry_t      w_head;

    // Credits cover both buffered entries and in-flight requests, so every
    // response always has a free slot.
    assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
    assign mem_req_valid = !reset && (r_state == RUN) && !redirect && (w_credit_used < C_DEPTH);
    assign mem_req_addr  = r_fetch_pc;
    assign w_redirect_pc = redirect_pc & C_PC_MASK;

    assign w_accept           = mem_req_valid && mem_req_ready;
    assign w_rsp_ok           = mem_rsp_valid && (r_outstanding != '0);
    assign w_push             = w_rsp_ok && (r_state == RUN) && !redirect;
    assign w_pop              = out_valid && out_ready && !redirect;
    assign w_outstanding_next = r_outstanding + CNT_W'(w_accept) - CNT_W'(w_rsp_ok);
    assign w_push_entry       = '{pc: r_rsp_pc, instr: mem_rsp_data};

    assign out_valid     = (w_fifo_count != '0);
    assign out_pc        = out_valid ? w_head.pc : '0;
    assign out_instr     = out_valid ? w_head.instr : '0;
    assign err_unexp_rsp = r_err_unexp;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect),
        .push      (w_push),
        .push_data (w_push_entry),
        .pop       (w_pop),
        .head_data (w_head),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (redirect) begin
            w_state_next = (w_outstanding_next != '0) ? DRAIN : RUN;
        end else if ((r_state == DRAIN) && (w_outstanding_next == '0)) begin
            w_state_next = RUN;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_err_unexp   <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (mem_rsp_valid && (r_outstanding == '0)) r_err_unexp <= 1'b1;
            if (redirect) begin
                r_fetch_pc <= w_redirect_pc;
                r_rsp_pc   <= w_redirect_pc;
            end else begin
                if (w_accept) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
                if (w_push)   r_rsp_pc   <= r_rsp_pc + ADDR_W'(4);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_prefetch_queue
// Description : Directed self-checking bench for fetch_prefetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_prefetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        err_unexp_rsp;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    fetch_prefetch_queue #(
        .DEPTH    (4),
        .RESET_PC (64'h2000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .out_valid     (out_valid),
        .out_pc        (out_pc),
        .out_instr     (out_instr),
        .out_ready     (out_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .err_unexp_rsp (err_unexp_rsp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic rsp(input logic v, input logic [31:0] d);
        mem_rsp_valid = v;
        mem_rsp_data  = d;
    endtask

    initial begin
        reset = 1'b1; mem_req_ready = 1'b0; out_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; rsp(1'b0, '0);
        settle();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_req_addr", mem_req_addr, 64'h2000);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_instr", out_instr, 0);
        chk("rst_err", err_unexp_rsp, 0);
        tick(); tick();
        reset = 1'b0;

        // 1: streaming, response one cycle after accept
        mem_req_ready = 1'b1; out_ready = 1'b1; settle();
        chk("t1_valid0", mem_req_valid, 1);
        chk("t1_addr0", mem_req_addr, 64'h2000);
        tick();
        rsp(1'b1, 32'hA000_0000); settle();
        chk("t1_addr1", mem_req_addr, 64'h2004);
        chk("t1_latency", out_valid, 0);
        tick();
        rsp(1'b1, 32'hA000_0001); settle();
        chk("t1_addr2", mem_req_addr, 64'h2008);
        chk("t1_pc0", out_pc, 64'h2000);
        chk("t1_instr0", out_instr, 32'hA000_0000);
        tick();
        rsp(1'b1, 32'hA000_0002); settle();
        chk("t1_addr3", mem_req_addr, 64'h200C);
        chk("t1_pc1", out_pc, 64'h2004);
        chk("t1_instr1", out_instr, 32'hA000_0001);
        tick();
        mem_req_ready = 1'b0; rsp(1'b1, 32'hA000_0003); settle();
        chk("t1_pc2", out_pc, 64'h2008);
        chk("t1_instr2", out_instr, 32'hA000_0002);
        tick();
        rsp(1'b0, '0); settle();
        chk("t1_pc3", out_pc, 64'h200C);
        chk("t1_instr3", out_instr, 32'hA000_0003);
        tick();

        // 2: decoder stalled, credit limit of 4
        out_ready = 1'b0; mem_req_ready = 1'b1; settle();
        chk("t2_empty", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            chk("t2_req_valid", mem_req_valid, 1);
            chk("t2_req_addr", mem_req_addr, 64'h2010 + 64'(4 * i));
            tick();
        end
        settle();
        chk("t2_credit_stop", mem_req_valid, 0);
        for (int i = 0; i < 4; i++) begin
            rsp(1'b1, 32'hB000_0000 + 32'(i)); settle();
            chk("t2_full_noreq", mem_req_valid, 0);
            tick();
        end
        rsp(1'b0, '0); settle();
        chk("t2_full_noreq2", mem_req_valid, 0);
        chk("t2_head_pc", out_pc, 64'h2010);
        chk("t2_head_instr", out_instr, 32'hB000_0000);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; settle();
        chk("t2_one_req", mem_req_valid, 1);
        chk("t2_one_addr", mem_req_addr, 64'h2020);
        chk("t2_head_pc2", out_pc, 64'h2014);
        tick();
        settle();
        chk("t2_one_only", mem_req_valid, 0);

        // 3: redirect with two outstanding -> drain
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0; settle();
        chk("t3_req", mem_req_addr, 64'h2024);
        tick();
        redirect = 1'b1; redirect_pc = 64'h3003; settle();
        chk("t3_redir_noreq", mem_req_valid, 0);
        tick();
        redirect = 1'b0; rsp(1'b1, 32'hDEAD_0001); settle();
        chk("t3_flushed", out_valid, 0);
        chk("t3_drain_noreq1", mem_req_valid, 0);
        tick();
        rsp(1'b1, 32'hDEAD_0002); settle();
        chk("t3_drain_noreq2", mem_req_valid, 0);
        tick();
        rsp(1'b0, '0); settle();
        chk("t3_stale_dropped", out_valid, 0);
        chk("t3_resume_valid", mem_req_valid, 1);
        chk("t3_resume_addr", mem_req_addr, 64'h3000);
        tick();
        mem_req_ready = 1'b0; rsp(1'b1, 32'hC000_0000);
        tick();
        rsp(1'b0, '0); settle();
        chk("t3_first_pc", out_pc, 64'h3000);
        chk("t3_first_instr", out_instr, 32'hC000_0000);

        // 4: redirect with nothing outstanding, concurrent pop ignored
        redirect = 1'b1; redirect_pc = 64'h4000; out_ready = 1'b1;
        tick();
        redirect = 1'b0; out_ready = 1'b0; mem_req_ready = 1'b1; settle();
        chk("t4_req_valid", mem_req_valid, 1);
        chk("t4_req_addr", mem_req_addr, 64'h4000);
        chk("t4_empty", out_valid, 0);
        tick();

        // 5: response and redirect in the same cycle, one outstanding
        redirect = 1'b1; redirect_pc = 64'h5000; rsp(1'b1, 32'hDEAD_0005);
        tick();
        redirect = 1'b0; rsp(1'b0, '0); mem_req_ready = 1'b0; settle();
        chk("t5_run_valid", mem_req_valid, 1);
        chk("t5_run_addr", mem_req_addr, 64'h5000);
        chk("t5_dropped", out_valid, 0);
        tick();

        // 6: address wrap, unsolicited response, reset during drain
        redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redirect = 1'b0; mem_req_ready = 1'b1; settle();
        chk("t6_top_addr", mem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        mem_req_ready = 1'b0; rsp(1'b1, 32'hE000_0000); settle();
        chk("t6_wrap_addr", mem_req_addr, 64'h0);
        tick();
        rsp(1'b1, 32'hBAD0_BAD0); settle();
        chk("t6_wrap_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_wrap_instr", out_instr, 32'hE000_0000);
        chk("t6_err_before", err_unexp_rsp, 0);
        tick();
        rsp(1'b0, '0); mem_req_ready = 1'b1; settle();
        chk("t6_err_set", err_unexp_rsp, 1);
        chk("t6_unexp_not_pushed", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t6_req_after_unexp", mem_req_addr, 64'h0);
        tick();
        mem_req_ready = 1'b0; redirect = 1'b1; redirect_pc = 64'h6000;
        tick();
        redirect = 1'b0; settle();
        chk("t6_drain_noreq", mem_req_valid, 0);
        chk("t6_err_sticky", err_unexp_rsp, 1);
        reset = 1'b1; settle();
        chk("t6_rst_req_valid", mem_req_valid, 0);
        chk("t6_rst_req_addr", mem_req_addr, 64'h2000);
        chk("t6_rst_out_valid", out_valid, 0);
        chk("t6_rst_out_pc", out_pc, 0);
        chk("t6_rst_out_instr", out_instr, 0);
        chk("t6_rst_err", err_unexp_rsp, 0);
        tick();
        reset = 1'b0; settle();
        chk("t6_post_rst_valid", mem_req_valid, 1);
        chk("t6_post_rst_addr", mem_req_addr, 64'h2000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
